// File: rtl/overlay_pkg.sv
// Shared widths, the shadow box record and the 50 % blend helper for box_overlay.
package overlay_pkg;
    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned C_W   = 8;
    localparam int unsigned RGB_W = 3 * C_W;

    typedef struct packed {
        logic             en;
        logic             fill;
        logic [X_W-1:0]   xs;
        logic [X_W-1:0]   xe;
        logic [Y_W-1:0]   ys;
        logic [Y_W-1:0]   ye;
        logic [RGB_W-1:0] color;
    } box_t;

    // Average of two channel values; the carry is kept so the sum never wraps.
    function automatic logic [C_W-1:0] blend50(input logic [C_W-1:0] a,
                                               input logic [C_W-1:0] b);
        logic [C_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[C_W:1];
    endfunction
endpackage

// File: rtl/box_hit.sv
// Combinational hit test of one shadow box against the current pixel coordinate.
module box_hit
    import overlay_pkg::*;
#(
    parameter int unsigned H_BOX_WIDTH = 2,
    parameter int unsigned V_BOX_WIDTH = 2
) (
    input  box_t           box,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic           inside_c,
    output logic           edge_c,
    output logic           blend_c
);
    localparam int unsigned XS_W = X_W + 1;
    localparam int unsigned YS_W = Y_W + 1;

    logic [XS_W-1:0] x_w;
    logic [XS_W-1:0] xs_w;
    logic [XS_W-1:0] xe_w;
    logic [YS_W-1:0] y_w;
    logic [YS_W-1:0] ys_w;
    logic [YS_W-1:0] ye_w;
    logic            in_box;
    logic            near_edge;
    logic            unused_color;

    assign x_w  = XS_W'(x);
    assign xs_w = XS_W'(box.xs);
    assign xe_w = XS_W'(box.xe);
    assign y_w  = YS_W'(y);
    assign ys_w = YS_W'(box.ys);
    assign ye_w = YS_W'(box.ye);

    // Inverted bounds can never satisfy both compares, so such boxes never hit.
    assign in_box = (box.xs <= x) && (x <= box.xe) && (box.ys <= y) && (y <= box.ye);

    // One extra bit on every sum keeps boxes touching the raster limit from wrapping.
    assign near_edge = (x_w < xs_w + XS_W'(H_BOX_WIDTH)) ||
                       (x_w + XS_W'(H_BOX_WIDTH) > xe_w) ||
                       (y_w < ys_w + YS_W'(V_BOX_WIDTH)) ||
                       (y_w + YS_W'(V_BOX_WIDTH) > ye_w);

    assign inside_c = box.en & in_box;
    assign edge_c   = inside_c & near_edge;
    assign blend_c  = inside_c & box.fill & ~near_edge;

    assign unused_color = ^box.color;
endmodule

// File: rtl/box_overlay.sv
// Overlays up to N_BOX outline or blended-fill rectangles on the HDMI pixel stream, 2-cycle latency.
module box_overlay
    import overlay_pkg::*;
#(
    parameter int unsigned N_BOX       = 4,
    parameter int unsigned H_BOX_WIDTH = 2,
    parameter int unsigned V_BOX_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_hsync,
    input  logic                   i_vsync,
    input  logic                   i_de,
    input  logic [X_W-1:0]         i_x,
    input  logic [Y_W-1:0]         i_y,
    input  logic [C_W-1:0]         i_r,
    input  logic [C_W-1:0]         i_g,
    input  logic [C_W-1:0]         i_b,
    input  logic [N_BOX-1:0]       box_en,
    input  logic [N_BOX-1:0]       box_fill,
    input  logic [X_W*N_BOX-1:0]   start_xs,
    input  logic [X_W*N_BOX-1:0]   end_xs,
    input  logic [Y_W*N_BOX-1:0]   start_ys,
    input  logic [Y_W*N_BOX-1:0]   end_ys,
    input  logic [RGB_W*N_BOX-1:0] colors,
    output logic                   o_hsync,
    output logic                   o_vsync,
    output logic                   o_de,
    output logic [C_W-1:0]         o_r,
    output logic [C_W-1:0]         o_g,
    output logic [C_W-1:0]         o_b,
    output logic                   committed
);
    box_t             live_c [N_BOX];
    box_t             shadow [N_BOX];
    logic             vs_q;
    logic             armed;
    logic             load_c;
    logic [N_BOX-1:0] inside_c;
    logic [N_BOX-1:0] edge_c;
    logic [N_BOX-1:0] blend_c;
    logic [N_BOX-1:0] inside_q;
    logic [N_BOX-1:0] edge_q;
    logic [N_BOX-1:0] blend_q;
    logic             hs_q;
    logic             de_q;
    logic [RGB_W-1:0] pix_q;
    logic [RGB_W-1:0] pix_c;
    logic             owned_c;

    genvar k;
    generate
        for (k = 0; k < N_BOX; k++) begin : g_box
            assign live_c[k] = {box_en[k], box_fill[k],
                                start_xs[k*X_W +: X_W], end_xs[k*X_W +: X_W],
                                start_ys[k*Y_W +: Y_W], end_ys[k*Y_W +: Y_W],
                                colors[k*RGB_W +: RGB_W]};

            box_hit #(
                .H_BOX_WIDTH (H_BOX_WIDTH),
                .V_BOX_WIDTH (V_BOX_WIDTH)
            ) u_hit (
                .box      (shadow[k]),
                .x        (i_x),
                .y        (i_y),
                .inside_c (inside_c[k]),
                .edge_c   (edge_c[k]),
                .blend_c  (blend_c[k])
            );
        end
    endgenerate

    // armed stays low until vsync has been seen low, so a vsync held high out of reset never commits.
    assign load_c = i_vsync & ~vs_q & armed;

    // Shadow geometry: loaded only on the vsync rising edge so a frame never tears.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_BOX; i++) begin
                shadow[i] <= '0;
            end
            armed     <= 1'b0;
            committed <= 1'b0;
        end else begin
            if (load_c) begin
                for (int i = 0; i < N_BOX; i++) begin
                    shadow[i] <= live_c[i];
                end
            end
            armed     <= armed | ~i_vsync;
            committed <= load_c;
        end
    end

    // Stage 1: per-box hit flags and the delayed timing and pixel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inside_q <= '0;
            edge_q   <= '0;
            blend_q  <= '0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            de_q     <= 1'b0;
            pix_q    <= '0;
        end else begin
            inside_q <= inside_c;
            edge_q   <= edge_c;
            blend_q  <= blend_c;
            hs_q     <= i_hsync;
            vs_q     <= i_vsync;
            de_q     <= i_de;
            pix_q    <= {i_r, i_g, i_b};
        end
    end

    // Stage 2 select: the lowest-index hitting box owns the pixel, even if it then passes it through.
    always_comb begin
        pix_c   = pix_q;
        owned_c = 1'b0;
        for (int i = 0; i < N_BOX; i++) begin
            if (!owned_c && inside_q[i]) begin
                owned_c = 1'b1;
                if (edge_q[i]) begin
                    pix_c = shadow[i].color;
                end else if (blend_q[i]) begin
                    pix_c = {blend50(pix_q[2*C_W +: C_W], shadow[i].color[2*C_W +: C_W]),
                             blend50(pix_q[C_W +: C_W],   shadow[i].color[C_W +: C_W]),
                             blend50(pix_q[0 +: C_W],     shadow[i].color[0 +: C_W])};
                end
            end
        end
        if (!de_q) begin
            pix_c = pix_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_hsync <= 1'b0;
            o_vsync <= 1'b0;
            o_de    <= 1'b0;
            o_r     <= '0;
            o_g     <= '0;
            o_b     <= '0;
        end else begin
            o_hsync <= hs_q;
            o_vsync <= vs_q;
            o_de    <= de_q;
            o_r     <= pix_c[2*C_W +: C_W];
            o_g     <= pix_c[C_W +: C_W];
            o_b     <= pix_c[0 +: C_W];
        end
    end
endmodule
